// File: rtl/mem_arbiter.sv
// Two-master word arbiter in front of the single-port test memory, with NXM timeout detection.
// Build with MEM_ARB_RR_EN defined for round-robin arbitration; otherwise m0 has fixed priority.
module mem_arbiter #(
    parameter int PADDR   = 18,
    parameter int WORD    = 36,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PADDR-1:0] m0_addr,
    input  logic [PADDR-1:0] m1_addr,
    input  logic [WORD-1:0]  m0_write_data,
    input  logic [WORD-1:0]  m1_write_data,
    input  logic             m0_read,
    input  logic             m1_read,
    input  logic             m0_write,
    input  logic             m1_write,
    output logic [WORD-1:0]  m0_read_data,
    output logic [WORD-1:0]  m1_read_data,
    output logic             m0_read_ack,
    output logic             m1_read_ack,
    output logic             m0_write_ack,
    output logic             m1_write_ack,
    output logic             m0_nxm,
    output logic             m1_nxm,
    output logic [PADDR-1:0] mem_addr,
    output logic [WORD-1:0]  mem_write_data,
    output logic             mem_read,
    output logic             mem_write,
    input  logic [WORD-1:0]  mem_read_data,
    input  logic             read_ack,
    input  logic             write_ack,
    output logic [1:0]       arb_state
);

    // Handshake: a master holds mX_read/mX_write high until its one-cycle ack and drops it at
    // the edge that samples the ack; memory gets one-cycle mem_read/mem_write pulses and
    // answers with one-cycle read_ack/write_ack pulses.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_TOUT  = 2'd3;
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] count;
    logic       owner;
    logic       tout_write;

    logic             req0, req1, win, win_read;
    logic [PADDR-1:0] win_addr;
    logic [WORD-1:0]  win_data;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef MEM_ARB_RR_EN
    logic last;

    assign win = (req0 && req1) ? ~last : ~req0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (state == S_IDLE && (req0 || req1)) begin
            last <= win;
        end
    end
`else
    assign win = ~req0;
`endif

    // A master raising read and write together gets the read first; the write stays pending.
    assign win_read = win ? m1_read : m0_read;
    assign win_addr = win ? m1_addr : m0_addr;
    assign win_data = win ? m1_write_data : m0_write_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            count          <= 8'd0;
            owner          <= 1'b0;
            tout_write     <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        owner          <= win;
                        mem_addr       <= win_addr;
                        mem_write_data <= win_data;
                        count          <= 8'd0;
                        tout_write     <= ~win_read;
                        if (win_read) begin
                            mem_read <= 1'b1;
                            state    <= S_READ;
                        end else begin
                            mem_write <= 1'b1;
                            state     <= S_WRITE;
                        end
                    end
                end
                S_READ: begin
                    count <= count + 8'd1;
                    if (read_ack) state <= S_IDLE;
                    else if (count == LAST_COUNT) state <= S_TOUT;
                end
                S_WRITE: begin
                    count <= count + 8'd1;
                    if (write_ack) state <= S_IDLE;
                    else if (count == LAST_COUNT) state <= S_TOUT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Acks are combinational so the requester sees them in the same cycle as the memory ack.
    logic ack_rd, ack_wr, nxm, rd_pass;

    assign rd_pass = (state == S_READ) && read_ack;
    assign ack_rd  = rd_pass || (state == S_TOUT && !tout_write);
    assign ack_wr  = ((state == S_WRITE) && write_ack) || (state == S_TOUT && tout_write);
    assign nxm     = (state == S_TOUT);

    assign m0_read_ack  = ack_rd & ~owner;
    assign m1_read_ack  = ack_rd & owner;
    assign m0_write_ack = ack_wr & ~owner;
    assign m1_write_ack = ack_wr & owner;
    assign m0_nxm       = nxm & ~owner;
    assign m1_nxm       = nxm & owner;
    assign m0_read_data = (rd_pass && !owner) ? mem_read_data : '0;
    assign m1_read_data = (rd_pass && owner) ? mem_read_data : '0;
    assign arb_state    = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle plus literal pins.
// Expectations for concurrent requests follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

    localparam int PADDR  = 18;
    localparam int WORD   = 36;
    localparam int TOUT_C = 4;

    logic             clk, reset;
    logic [PADDR-1:0] m0_addr, m1_addr, mem_addr;
    logic [WORD-1:0]  m0_write_data, m1_write_data, m0_read_data, m1_read_data;
    logic             m0_read, m1_read, m0_write, m1_write;
    logic             m0_read_ack, m1_read_ack, m0_write_ack, m1_write_ack, m0_nxm, m1_nxm;
    logic [WORD-1:0]  mem_write_data, mem_read_data;
    logic             mem_read, mem_write, read_ack, write_ack;
    logic [1:0]       arb_state;

    mem_arbiter #(.PADDR(PADDR), .WORD(WORD), .TIMEOUT(TOUT_C)) dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_write_data(m0_write_data), .m1_write_data(m1_write_data),
        .m0_read(m0_read), .m1_read(m1_read), .m0_write(m0_write), .m1_write(m1_write),
        .m0_read_data(m0_read_data), .m1_read_data(m1_read_data),
        .m0_read_ack(m0_read_ack), .m1_read_ack(m1_read_ack),
        .m0_write_ack(m0_write_ack), .m1_write_ack(m1_write_ack),
        .m0_nxm(m0_nxm), .m1_nxm(m1_nxm),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data), .read_ack(read_ack), .write_ack(write_ack),
        .arb_state(arb_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        logic            m;
        logic            wr;
        logic            nxm;
        logic [WORD-1:0] data;
    } ev_t;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  last_strobe = -1;
    ev_t ev_q[$];
    logic [0:0] exp_q[$];

    logic [WORD-1:0] store  [logic [PADDR-1:0]];
    logic [WORD-1:0] shadow [logic [PADDR-1:0]];

    // memory responder and master behaviour
    logic             rd_pend = 1'b0, wr_pend = 1'b0, suppress = 1'b0, inject = 1'b0;
    logic [PADDR-1:0] rd_addr = '0;
    logic             auto0 = 1'b0, auto1 = 1'b0;

    // transaction model: one access at a time, age counts cycles since the grant edge
    logic             m_act = 1'b0, m_own = 1'b0, m_kind = 1'b0, m_last = 1'b1;
    int               m_age = 0;
    logic [PADDR-1:0] m_addr = '0;
    logic [WORD-1:0]  m_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WORD-1:0] shadow_rd(input logic [PADDR-1:0] a);
        return shadow.exists(a) ? shadow[a] : '0;
    endfunction

    function automatic logic [WORD-1:0] store_rd(input logic [PADDR-1:0] a);
        return store.exists(a) ? store[a] : '0;
    endfunction

    function automatic ev_t get_ev(input int i);
        ev_t e;
        e = '{-1, 1'b0, 1'b0, 1'b0, '0};
        if (i < ev_q.size()) e = ev_q[i];
        return e;
    endfunction

    task automatic compare_cycle();
        logic e_mr, e_mw, e_rd, e_wr, e_nx, done, r0, r1, w;
        logic [WORD-1:0] e_dat;
        e_mr = 1'b0; e_mw = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_nx = 1'b0; done = 1'b0;
        e_dat = '0;
        if (m_act) begin
            e_mr = (m_age == 1) && !m_kind;
            e_mw = (m_age == 1) && m_kind;
            chk("mem_addr", 64'(mem_addr), 64'(m_addr));
            chk("mem_write_data", 64'(mem_write_data), 64'(m_data));
            if (m_age == TOUT_C + 1) begin
                e_rd = !m_kind; e_wr = m_kind; e_nx = 1'b1; done = 1'b1;
            end else if (!m_kind && read_ack) begin
                e_rd = 1'b1; e_dat = shadow_rd(m_addr); done = 1'b1;
            end else if (m_kind && write_ack) begin
                e_wr = 1'b1; shadow[m_addr] = m_data; done = 1'b1;
            end
        end
        chk("mem_read", 64'(mem_read), 64'(e_mr));
        chk("mem_write", 64'(mem_write), 64'(e_mw));
        chk("m0_ack_nxm", 64'({m0_read_ack, m0_write_ack, m0_nxm}),
            64'(m_own ? 3'b000 : {e_rd, e_wr, e_nx}));
        chk("m1_ack_nxm", 64'({m1_read_ack, m1_write_ack, m1_nxm}),
            64'(m_own ? {e_rd, e_wr, e_nx} : 3'b000));
        chk("m0_read_data", 64'(m0_read_data), 64'((!m_own && e_rd) ? e_dat : '0));
        chk("m1_read_data", 64'(m1_read_data), 64'((m_own && e_rd) ? e_dat : '0));

        if (mem_read || mem_write) last_strobe = cyc;
        if (m0_read_ack || m0_write_ack)
            ev_q.push_back('{cyc, 1'b0, m0_write_ack, m0_nxm, m0_read_data});
        if (m1_read_ack || m1_write_ack)
            ev_q.push_back('{cyc, 1'b1, m1_write_ack, m1_nxm, m1_read_data});

        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (done) begin
            m_act = 1'b0;
        end else if (m_act) begin
            m_age++;
        end else if (r0 || r1) begin
`ifdef MEM_ARB_RR_EN
            w = (r0 && r1) ? !m_last : !r0;
`else
            w = !r0;
`endif
            m_act  = 1'b1;
            m_age  = 1;
            m_own  = w;
            m_kind = w ? !m1_read : !m0_read;
            m_addr = w ? m1_addr : m0_addr;
            m_data = w ? m1_write_data : m0_write_data;
            m_last = w;
        end
        cyc++;
    endtask

    // One cycle: compare at the falling edge, then memory and masters react after the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
        read_ack = 1'b0; write_ack = 1'b0; mem_read_data = '0;
        if (rd_pend && !suppress) begin
            read_ack = 1'b1;
            mem_read_data = store_rd(rd_addr);
        end
        if (wr_pend && !suppress) write_ack = 1'b1;
        if (inject) begin
            read_ack = 1'b1;
            inject = 1'b0;
        end
        rd_pend = mem_read;
        wr_pend = mem_write;
        rd_addr = mem_addr;
        if (mem_write) store[mem_addr] = mem_write_data;
        #1;
        if (m0_read_ack) m0_read = 1'b0;
        if (m0_write_ack) m0_write = 1'b0;
        if (m1_read_ack) m1_read = 1'b0;
        if (m1_write_ack) m1_write = 1'b0;
        if (auto0 && !m0_read_ack && !m0_write_ack && !m0_write) m0_read = 1'b1;
        if (auto1 && !m1_read_ack && !m1_write_ack && !m1_write) m1_read = 1'b1;
    endtask

    task automatic wait_events(input int n, input int budget);
        int k;
        k = 0;
        while (ev_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (ev_q.size() < n) chk("event_wait_expired", 64'(ev_q.size()), 64'(n));
    endtask

    task automatic preload(input logic [PADDR-1:0] a, input logic [WORD-1:0] d);
        store[a]  = d;
        shadow[a] = d;
    endtask

    task automatic m_issue(input logic m, input logic rd, input logic wr,
                           input logic [PADDR-1:0] a, input logic [WORD-1:0] d);
        if (!m) begin
            m0_addr = a; m0_write_data = d; m0_read = rd; m0_write = wr;
        end else begin
            m1_addr = a; m1_write_data = d; m1_read = rd; m1_write = wr;
        end
    endtask

    initial begin
        int  c0, n0, k;
        ev_t e, e2;
        reset = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_write_data = '0; m1_write_data = '0;
        m0_read = 1'b0; m1_read = 1'b0; m0_write = 1'b0; m1_write = 1'b0;
        mem_read_data = '0; read_ack = 1'b0; write_ack = 1'b0;
        preload(18'o000100, 36'o123456654321);
        preload(18'o000300, 36'o111111222222);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mem_rw", 64'({mem_read, mem_write}), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_write_data), 64'(0));
        chk("rst_state", 64'(arb_state), 64'(0));
        reset = 1'b1;
        #1;

        // single read by m0 against a zero-wait memory
        c0 = cyc; n0 = ev_q.size();
        m_issue(1'b0, 1'b1, 1'b0, 18'o000100, '0);
        wait_events(n0 + 1, 10);
        e = get_ev(n0);
        chk("t1_strobe_cyc", 64'(last_strobe), 64'(c0 + 1));
        chk("t1_ack_cyc", 64'(e.cyc), 64'(c0 + 2));
        chk("t1_master", 64'(e.m), 64'(0));
        chk("t1_data", 64'(e.data), 64'(36'o123456654321));
        chk("t1_nxm", 64'(e.nxm), 64'(0));
        tick();

        // m1 write then read back
        c0 = cyc; n0 = ev_q.size();
        m_issue(1'b1, 1'b0, 1'b1, 18'o000200, 36'o777777000001);
        wait_events(n0 + 1, 10);
        e = get_ev(n0);
        chk("t2_wack_cyc", 64'(e.cyc), 64'(c0 + 2));
        chk("t2_wack_kind", 64'({e.m, e.wr, e.nxm}), 64'(3'b110));
        tick();
        n0 = ev_q.size();
        m_issue(1'b1, 1'b1, 1'b0, 18'o000200, '0);
        wait_events(n0 + 1, 10);
        e = get_ev(n0);
        chk("t2_rdata", 64'(e.data), 64'(36'o777777000001));
        tick();

        // both masters read continuously for 12 cycles
`ifdef MEM_ARB_RR_EN
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        c0 = cyc; n0 = ev_q.size();
        m0_addr = 18'o000100; m1_addr = 18'o000200;
        m0_read = 1'b1; m1_read = 1'b1; auto0 = 1'b1; auto1 = 1'b1;
        repeat (12) tick();
        auto0 = 1'b0; auto1 = 1'b0;
        k = 0;
        while ((m0_read || m1_read || m_act) && k < 30) begin
            tick();
            k++;
        end
        chk("t3_quiesce", 64'({m0_read, m1_read}), 64'(0));
        k = 0;
        for (int i = n0; i < ev_q.size(); i++) if (ev_q[i].cyc < c0 + 12) k++;
        chk("t3_grants_in_window", 64'(k), 64'(4));
        for (int i = 0; i < 4; i++) begin
            e = get_ev(n0 + i);
            chk($sformatf("t3_grant%0d", i), 64'(e.m), 64'(exp_q[i]));
        end
        tick();

        // same master read+write together: read first, write next
        n0 = ev_q.size();
        m_issue(1'b0, 1'b1, 1'b1, 18'o000300, 36'o333333444444);
        wait_events(n0 + 2, 20);
        e = get_ev(n0); e2 = get_ev(n0 + 1);
        chk("t4_first_is_read", 64'({e.wr, e.data}), 64'({1'b0, 36'o111111222222}));
        chk("t4_second_is_write", 64'(e2.wr), 64'(1));
        chk("t4_spacing", 64'(e2.cyc - e.cyc), 64'(3));
        tick();
        n0 = ev_q.size();
        m_issue(1'b0, 1'b1, 1'b0, 18'o000300, '0);
        wait_events(n0 + 1, 10);
        e = get_ev(n0);
        chk("t4_readback", 64'(e.data), 64'(36'o333333444444));
        tick();

        // suppressed memory ack: NXM after timeout, then a stray ack in IDLE
        suppress = 1'b1;
        c0 = cyc; n0 = ev_q.size();
        m_issue(1'b0, 1'b1, 1'b0, 18'o000400, '0);
        wait_events(n0 + 1, 20);
        e = get_ev(n0);
        chk("t5_nxm_cyc", 64'(e.cyc - last_strobe), 64'(TOUT_C));
        chk("t5_nxm_after_req", 64'(e.cyc), 64'(c0 + TOUT_C + 1));
        chk("t5_nxm_flags", 64'({e.m, e.wr, e.nxm}), 64'(3'b001));
        chk("t5_nxm_data", 64'(e.data), 64'(0));
        suppress = 1'b0;
        inject = 1'b1;
        n0 = ev_q.size();
        repeat (4) tick();
        chk("t5_late_ack_ignored", 64'(ev_q.size()), 64'(n0));

        // reset pulse while mem_write is high
        m_issue(1'b0, 1'b0, 1'b1, 18'o000500, 36'o525252525252);
        k = 0;
        while (!mem_write && k < 6) begin
            tick();
            k++;
        end
        chk("t6_strobe_seen", 64'(mem_write), 64'(1));
        reset = 1'b0;
        #1;
        chk("t6_async_mem", 64'({mem_read, mem_write, mem_addr, mem_write_data}), 64'(0));
        chk("t6_async_acks", 64'({m0_read_ack, m0_write_ack, m0_nxm,
                                  m1_read_ack, m1_write_ack, m1_nxm}), 64'(0));
        m0_write = 1'b0;
        reset = 1'b1;
        m_act = 1'b0; m_last = 1'b1;
        n0 = ev_q.size();
        repeat (4) tick();
        chk("t6_no_write_ack", 64'(ev_q.size()), 64'(n0));
        c0 = cyc;
        m_issue(1'b0, 1'b1, 1'b0, 18'o000100, '0);
        wait_events(n0 + 1, 10);
        e = get_ev(n0);
        chk("t6_after_reset_cyc", 64'(e.cyc), 64'(c0 + 2));
        chk("t6_after_reset_data", 64'(e.data), 64'(36'o123456654321));
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
